red_secuencial: RTL
===================

# red_secuencial

Bit-serial sequencer for the left-to-right iterative comparison network: it performs the same cell-by-cell comparison, but over K clock cycles through one reused cell instead of K replicated cells. It captures a K-bit operand pair through a valid/ready handshake and walks the bits from index K-1 down to 0, carrying the (M,N) cell state in a register. It returns the comparison result through a second valid/ready handshake. It sits between the operand source and any consumer that trades latency for area.

## Interface
- K, 5: operand width; legal for K >= 1.
- EARLY_EXIT, 1: when 1, the block finishes as soon as the cell state is decided. When 0, it always processes all K bits.
- CW, $clog2(K+1): width of the cycle counter output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present on A and B.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  K  first operand; sampled only at the accept edge.
- B  input  K  second operand; sampled only at the accept edge.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- Z  output  1  1 when A > B, with bit K-1 the most significant.
- E  output  1  1 when A == B.
- M  output  1  current registered cell state bit M.
- N  output  1  current registered cell state bit N.
- busy  output  1  high in RUN.
- ciclos  output  CW  number of bits processed for the current or last result.

## Operation
- Cell state (M,N) encoding:
  - 00 means undecided.
  - 10 means A is greater.
  - 01 means B is greater.
  - 11 never occurs; decode it as undecided and flag it with an assertion.
- Cell step for bit i, applied only while the state is undecided:
  - A[i]=1 and B[i]=0 sets the state to 10.
  - A[i]=0 and B[i]=1 sets the state to 01.
  - Otherwise the state stays 00.
- A decided state is sticky until the next accept.
- FSM states:
  - IDLE to RUN on in_valid && in_ready. At that edge the block captures A and B, clears the state to 00, sets idx=K-1 and clears ciclos to 0.
  - RUN processes bit idx at every edge, increments ciclos and decrements idx. It moves to DONE when idx==0, or when EARLY_EXIT=1 and the post-step state is decided.
  - DONE to IDLE on out_valid && out_ready.
- Result outputs:
  - Z = (state==10).
  - E = (state==00) is valid only in DONE.
  - Z and E are held stable throughout DONE.
- Ignored inputs:
  - in_valid is ignored in RUN and DONE.
  - Changes on A and B after the accept edge have no effect.
- The output handshake releases the result at the DONE-to-IDLE edge. in_ready rises in the following cycle; there is no same-cycle turnaround.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - FSM state is IDLE, so in_ready=1.
  - out_valid=0, busy=0, Z=0, E=0, M=0, N=0, ciclos=0.
- Reset mid-operation aborts immediately: the current result is discarded, out_valid is never asserted for it, and the block resumes in IDLE.
- Latency, counted from the accept edge (edge 0):
  - Full run: out_valid is high after edge K, with ciclos=K.
  - Early exit on bit j: out_valid is high after edge K-j, with ciclos=K-j.
- in_ready, out_valid and busy are decoded from registered state only; there are no combinational input-to-output paths.
- K=1: a single RUN cycle, then DONE.
- Throughput: a new operand pair can be accepted at most once per K+2 cycles when out_ready is held high.

## Structure
- Shared package red_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the cell-state localparams (INDECISO=2'b00, A_MAYOR=2'b10, B_MAYOR=2'b01).
- Sub-module celda_secuencial is a purely combinational one-bit step: inputs m, n, a, b; outputs M, N. It is instantiated once; the registers and the FSM live in red_secuencial.

## Test plan
- Early exit: K=5, EARLY_EXIT=1, A=10110, B=10011, out_ready=1.
  - Required: out_valid after 3 RUN cycles, Z=1, E=0, ciclos=3.
- Equal operands: A=B=01101.
  - Required: 5 RUN cycles, Z=0, E=1, ciclos=5.
- B greater with and without early exit: A=00000, B=10000.
  - With EARLY_EXIT=1: out_valid after 1 cycle, Z=0, E=0, ciclos=1.
  - With EARLY_EXIT=0: same Z and E, ciclos=5.
- Backpressure: hold out_ready=0 for 4 cycles in DONE while pulsing in_valid with new operands.
  - Required: Z, E and ciclos stay stable; in_ready=0; no new capture.
  - Required: IDLE one cycle after out_ready=1.
- Reset mid-operation: assert rst_n=0 during the second RUN cycle.
  - Required: all outputs take their reset values without waiting for a clock edge; no out_valid.
  - Required: the next transaction (A=00011, B=00010) gives Z=1, ciclos=5.
- K=1 cases, checking Z, E and ciclos=1 for each:
  - A=1, B=0 gives Z=1.
  - A=0, B=1 gives Z=0, E=0.
  - A=1, B=1 gives E=1.

Source files
------------

// File: rtl/red_pkg.sv
// red_pkg: shared FSM state type and cell-state codes for the serial comparator
package red_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [1:0] INDECISO = 2'b00;
    localparam logic [1:0] A_MAYOR  = 2'b10;
    localparam logic [1:0] B_MAYOR  = 2'b01;
endpackage

// File: rtl/red_secuencial_if.sv
// red_secuencial_if: operand and result valid/ready channels of the serial comparator
interface red_secuencial_if #(parameter int K = 5);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] A;
    logic [K-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic         Z;
    logic         E;
    modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Z, E);
    modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, Z, E);
endinterface

// File: rtl/celda_secuencial.sv
// celda_secuencial: one combinational comparison step; a decided state passes through unchanged
module celda_secuencial
    import red_pkg::*;
(
    input  logic m,
    input  logic n,
    input  logic a,
    input  logic b,
    output logic M,
    output logic N
);
    // 11 is treated like 00 (undecided) so the step can still resolve it
    assign {M, N} = (m ^ n) ? {m, n} : (a & ~b) ? A_MAYOR : (~a & b) ? B_MAYOR : INDECISO;
endmodule

// File: rtl/red_secuencial.sv
// red_secuencial: bit-serial MSB-first magnitude comparator with valid/ready handshakes
module red_secuencial
    import red_pkg::*;
#(
    parameter int K = 5,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CW = $clog2(K + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    red_secuencial_if.slave bus,
    output logic            M,
    output logic            N,
    output logic            busy,
    output logic [CW-1:0]   ciclos
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    state_t st, st_nx;
    logic [K-1:0] a_r, b_r;
    logic [IW-1:0] idx;
    logic cm, cn;
    celda_secuencial u_celda (.m(M), .n(N), .a(a_r[idx]), .b(b_r[idx]), .M(cm), .N(cn));
    assign bus.in_ready  = st == IDLE;
    assign bus.out_valid = st == DONE;
    assign busy          = st == RUN;
    assign bus.Z         = M & ~N;
    assign bus.E         = (st == DONE) & ~(M ^ N);
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else st <= st_nx;
    // next state: accept, step until last bit or decided, hold until consumer takes result
    always_comb begin
        st_nx = st;
        if (st == IDLE && bus.in_valid) st_nx = RUN;
        if (st == RUN && (idx == '0 || (EARLY_EXIT && (cm ^ cn)))) st_nx = DONE;
        if (st == DONE && bus.out_ready) st_nx = IDLE;
    end
    // operand capture and per-bit cell-state / counter update
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            {M, N} <= INDECISO;
            idx    <= '0;
            ciclos <= '0;
        end else if (st == IDLE && bus.in_valid) begin
            a_r    <= bus.A;
            b_r    <= bus.B;
            {M, N} <= INDECISO;
            idx    <= IW'(K - 1);
            ciclos <= '0;
        end else if (st == RUN) begin
            {M, N} <= {cm, cn};
            idx    <= idx - 1'b1;
            ciclos <= ciclos + 1'b1;
        end
    // the cell never produces both flags at once
    a_no_11: assert property (@(posedge clk) disable iff (!rst_n) {M, N} != 2'b11);
endmodule
